regfile_dumper: RTL

//  Debug reader on the far side of the regfile write path. On request it walks

---
 rtl/regfile_dumper_pkg.sv | 11 +
 rtl/regfile_dumper.sv | 59 +++++
 2 files changed

// File: rtl/regfile_dumper_pkg.sv
// regfile_dumper_pkg: state encoding and regfile widths shared with the dumper
package regfile_dumper_pkg;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 4;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;
endpackage

// File: rtl/regfile_dumper.sv
// regfile_dumper: walks every register through one read port and streams (idx, data, last) beats
module regfile_dumper import regfile_dumper_pkg::*; #(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_REGS = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] rf_sel,
  input  logic [DATA_W-1:0] rf_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_idx,
  output logic              out_last,
  output logic              busy,
  output logic              cpu_stall,
  output logic              done
);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);
  state_t            state, nxt;
  logic [ADDR_W-1:0] idx;
  logic              hs;
  assign busy      = state != IDLE;
  assign cpu_stall = busy;
  assign done      = state == DONE && !abort;
  assign rf_sel    = (state == LOAD || state == SEND) ? idx : '0;
  // next state: abort from any busy state wins over everything else
  always_comb begin
    hs  = out_valid && out_ready;
    nxt = (abort && state != IDLE) ? IDLE :
          state == IDLE ? (start ? LOAD : IDLE) :
          state == LOAD ? SEND :
          state == SEND ? (hs ? (out_last ? DONE : LOAD) : SEND) : IDLE;
  end
  // state, walk index and the output beat register captured at the LOAD edge
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
    end else begin
      state     <= nxt;
      out_valid <= nxt == SEND;
      if (state == IDLE && start) idx <= '0;
      if (state == LOAD) begin
        out_data <= rf_data;
        out_idx  <= idx;
        out_last <= idx == LAST_IDX;
      end
      if (state == SEND && hs && !out_last) idx <= idx + ADDR_W'(1);
    end
  end
endmodule
